// File: rtl/rr_record_stream_packer_pkg.sv
// Shared definitions for the record stream: channel-width table type and the
// width/offset/length helpers also used by the backend's length decode.
package rr_record_stream_packer_pkg;

    localparam int RR_CHANNEL_WIDTH_BITS = 8;
    localparam int RR_MAX_CHANNELS       = 16;

    // Zero-extended channel-width table so helpers work for any channel count.
    typedef bit [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_width_tab_t;

    function automatic int rr_sum_widths(input rr_width_tab_t widths, input int cnt);
        int s;
        s = 0;
        for (int i = 0; i < RR_MAX_CHANNELS; i++)
            if (i < cnt) s += int'(widths[i]);
        return s;
    endfunction

    // Exclusive prefix sum of the widths of the flagged channels below idx.
    function automatic int rr_prefix_offset(input rr_width_tab_t widths,
                                            input logic [RR_MAX_CHANNELS-1:0] valid,
                                            input int idx);
        int s;
        s = 0;
        for (int j = 0; j < RR_MAX_CHANNELS; j++)
            if (j < idx && valid[j]) s += int'(widths[j]);
        return s;
    endfunction

    // Packed unit length: both bitmaps plus the data of the valid logb channels.
    function automatic int rr_get_len(input rr_width_tab_t widths,
                                      input logic [RR_MAX_CHANNELS-1:0] valid,
                                      input int logb_cnt,
                                      input int loge_cnt);
        return logb_cnt + loge_cnt + rr_prefix_offset(widths, valid, logb_cnt);
    endfunction

endpackage

// File: rtl/rr_record_stream_packer_offsets.sv
// Combinational prefix offsets of the valid channels inside the packed unit,
// plus the total packed length. Offsets already include the bitmap header.
module rr_packer_offsets
    import rr_record_stream_packer_pkg::*;
#(
    parameter int LOGB_CHANNEL_CNT = 3,
    parameter int LOGE_CHANNEL_CNT = 2,
    parameter bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {8'd32, 8'd16, 8'd8},
    parameter int OFFSET_WIDTH = 6
) (
    input  logic [LOGB_CHANNEL_CNT-1:0]                   logb_valid,
    output logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] offsets,
    output logic [OFFSET_WIDTH-1:0]                       len
);

    localparam int HDR_WIDTH = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;

    logic [OFFSET_WIDTH-1:0] run;

    // Running offset accumulated at OFFSET_WIDTH; the packed length never exceeds it.
    always_comb begin
        run     = OFFSET_WIDTH'(HDR_WIDTH);
        offsets = '0;
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            offsets[i] = run;
            if (logb_valid[i]) run = run + OFFSET_WIDTH'(CHANNEL_WIDTHS[i]);
        end
        len = run;
    end

endmodule

// File: rtl/rr_record_stream_packer.sv
// Two-stage packer: S1 registers the sparse unit with its channel offsets,
// S2 compacts it into the packed record layout for the backend consumer.
module rr_record_stream_packer
    import rr_record_stream_packer_pkg::*;
#(
    parameter int LOGB_CHANNEL_CNT = 3,
    parameter int LOGE_CHANNEL_CNT = 2,
    parameter bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {8'd32, 8'd16, 8'd8},
    localparam int DATA_WIDTH   = rr_sum_widths(rr_width_tab_t'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT),
    localparam int FULL_WIDTH   = DATA_WIDTH + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
    localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
    input  logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid,
    input  logic [DATA_WIDTH-1:0]       in_logb_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [FULL_WIDTH-1:0]       out_data,
    output logic [OFFSET_WIDTH-1:0]     out_len,
    output logic [31:0]                 unit_cnt,
    output logic [63:0]                 bit_cnt,
    output logic [31:0]                 drop_cnt
);

    localparam int            HDR_WIDTH = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
    localparam rr_width_tab_t WTAB      = rr_width_tab_t'(CHANNEL_WIDTHS);

    logic                                         s1_v;
    logic                                         s1_empty;
    logic [LOGB_CHANNEL_CNT-1:0]                  s1_logb;
    logic [LOGE_CHANNEL_CNT-1:0]                  s1_loge;
    logic [DATA_WIDTH-1:0]                        s1_data;
    logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] s1_off;
    logic [OFFSET_WIDTH-1:0]                      s1_len;
    logic                                         s2_v;

    logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] c_off;
    logic [OFFSET_WIDTH-1:0]                      c_len;
    logic [LOGB_CHANNEL_CNT-1:0][FULL_WIDTH-1:0]  chan_ext;
    logic [FULL_WIDTH-1:0]                        pack;

    logic in_fire;
    logic in_empty;
    logic out_fire;
    logic s1_adv;
    logic s2_load;

    rr_packer_offsets #(
        .LOGB_CHANNEL_CNT (LOGB_CHANNEL_CNT),
        .LOGE_CHANNEL_CNT (LOGE_CHANNEL_CNT),
        .CHANNEL_WIDTHS   (CHANNEL_WIDTHS),
        .OFFSET_WIDTH     (OFFSET_WIDTH)
    ) u_offsets (
        .logb_valid (in_logb_valid),
        .offsets    (c_off),
        .len        (c_len)
    );

    assign in_ready  = !rst && (!s1_v || !s2_v || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign in_empty  = ~|{in_loge_valid, in_logb_valid};
    assign out_fire  = s2_v && out_ready;
    // Empty units retire straight out of S1 and never take an S2 slot.
    assign s1_adv    = s1_v && (s1_empty || !s2_v || out_ready);
    assign s2_load   = s1_v && !s1_empty && (!s2_v || out_ready);
    assign out_valid = s2_v;

    // Each channel lifted from its fixed input slot, zero-extended to the packed width.
    for (genvar g = 0; g < LOGB_CHANNEL_CNT; g++) begin : g_chan
        localparam int LO = rr_prefix_offset(WTAB, {RR_MAX_CHANNELS{1'b1}}, g);
        localparam int W  = int'(WTAB[g]);
        assign chan_ext[g] = FULL_WIDTH'(s1_data[LO +: W]);
    end

    // Compaction: header bitmaps, then each valid channel OR-ed in at its offset.
    always_comb begin
        pack = '0;
        pack[HDR_WIDTH-1:0] = {s1_loge, s1_logb};
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++)
            if (s1_logb[i]) pack = pack | (chan_ext[i] << s1_off[i]);
    end

    // S1: capture the sparse unit together with its offsets and length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_empty <= 1'b0;
            s1_logb  <= '0;
            s1_loge  <= '0;
            s1_data  <= '0;
            s1_off   <= '0;
            s1_len   <= '0;
        end else if (in_fire) begin
            s1_v     <= 1'b1;
            s1_empty <= in_empty;
            s1_logb  <= in_logb_valid;
            s1_loge  <= in_loge_valid;
            s1_data  <= in_logb_data;
            s1_off   <= c_off;
            s1_len   <= c_len;
        end else if (s1_adv) begin
            s1_v     <= 1'b0;
        end
    end

    // S2: registered packed output, held steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v     <= 1'b0;
            out_data <= '0;
            out_len  <= '0;
        end else if (s2_load) begin
            s2_v     <= 1'b1;
            out_data <= pack;
            out_len  <= s1_len;
        end else if (out_fire) begin
            s2_v     <= 1'b0;
        end
    end

    // Statistics: handed-off units and bits, and discarded empty units.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_cnt <= '0;
            bit_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (out_fire) begin
                unit_cnt <= unit_cnt + 32'd1;
                bit_cnt  <= bit_cnt + 64'(out_len);
            end
            if (in_fire && in_empty) drop_cnt <= drop_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_rr_record_stream_packer.sv
// Bench for rr_record_stream_packer at default parameters (61-bit unit, 6-bit length).
module tb_rr_record_stream_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_logb_valid;
    logic [1:0]  in_loge_valid;
    logic [55:0] in_logb_data;
    logic        out_valid;
    logic        out_ready;
    logic [60:0] out_data;
    logic [5:0]  out_len;
    logic [31:0] unit_cnt;
    logic [63:0] bit_cnt;
    logic [31:0] drop_cnt;

    rr_record_stream_packer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_logb_valid (in_logb_valid),
        .in_loge_valid (in_loge_valid),
        .in_logb_data  (in_logb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_len       (out_len),
        .unit_cnt      (unit_cnt),
        .bit_cnt       (bit_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  len;
        logic [60:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [2:0]  lb;
        logic [1:0]  le;
        logic [55:0] d;
        logic [5:0]  len;
        logic [60:0] data;
    } vec_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] exp_units = 0;
    logic [63:0] exp_drops = 0;
    logic [63:0] exp_bits  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end
    endtask

    // Independent bit-by-bit reference packer.
    function automatic exp_t ref_pack(input logic [2:0] lb, input logic [1:0] le, input logic [55:0] d);
        int   w[3]  = '{8, 16, 32};
        int   lo[3] = '{0, 8, 24};
        int   pos;
        exp_t r;
        r.data      = '0;
        r.data[2:0] = lb;
        r.data[4:3] = le;
        pos = 5;
        for (int i = 0; i < 3; i++) begin
            if (lb[i]) begin
                for (int b = 0; b < w[i]; b++) r.data[pos + b] = d[lo[i] + b];
                pos += w[i];
            end
        end
        r.len = 6'(pos);
        r.due = -1;
        return r;
    endfunction

    // Output monitor: scoreboard compare, fixed-latency check and stall stability.
    exp_t        mon_e;
    logic        prev_stall = 1'b0;
    logic [60:0] prev_data;
    logic [5:0]  prev_len;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", {3'd0, out_data}, {3'd0, prev_data});
                chk("stall_len", {58'd0, out_len}, {58'd0, prev_len});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got len=%0d data=%0h, required no output", out_len, out_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_len", {58'd0, out_len}, {58'd0, mon_e.len});
                    chk("out_data", {3'd0, out_data}, {3'd0, mon_e.data});
                    if (mon_e.due >= 0) chk("latency_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_len   = out_len;
        end
    end

    // Offer one unit (entered at posedge+1); returns after its handshake edge.
    task automatic send(input logic [2:0] lb, input logic [1:0] le, input logic [55:0] d,
                        input exp_t e, input bit timed, output int waits);
        bit   hs;
        exp_t ee;
        hs = 1'b0;
        waits = 0;
        in_valid      = 1'b1;
        in_logb_valid = lb;
        in_loge_valid = le;
        in_logb_data  = d;
        while (!hs && waits < 40) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (!hs) waits++;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no handshake in %0d cycles, required acceptance", waits);
        end else if (lb == 3'b0 && le == 2'b0) begin
            exp_drops++;
        end else begin
            ee = e;
            ee.due = timed ? cyc + 1 : -1;
            sb.push_back(ee);
            exp_units++;
            exp_bits += 64'(e.len);
        end
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_logb_valid = 3'($urandom);
        in_loge_valid = 2'($urandom);
        in_logb_data  = {$urandom, 24'($urandom)};
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_unit_cnt"}, {32'd0, unit_cnt}, {32'd0, exp_units[31:0]});
        chk({tag, "_drop_cnt"}, {32'd0, drop_cnt}, {32'd0, exp_drops[31:0]});
        chk({tag, "_bit_cnt"}, bit_cnt, exp_bits);
    endtask

    vec_t        vecs[6];
    exp_t        e;
    int          w;
    int          stalls;
    logic [2:0]  lb;
    logic [1:0]  le;
    logic [55:0] d;
    exp_t        bp[4];
    logic [2:0]  bp_lb[4];
    logic [55:0] bp_d[4];

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b101, 2'b00, {32'hDEADBEEF, 16'hFFFF, 8'hA5}, 6'd45,
                    {16'h0, 32'hDEADBEEF, 8'hA5, 2'b00, 3'b101}};
        vecs[1] = '{3'b000, 2'b10, {32'h12345678, 16'h9ABC, 8'hDE}, 6'd5, 61'h10};
        vecs[2] = '{3'b111, 2'b11, {32'h789ABCDE, 16'h3456, 8'h12}, 6'd61,
                    {32'h789ABCDE, 16'h3456, 8'h12, 2'b11, 3'b111}};
        vecs[3] = '{3'b010, 2'b01, {32'hFFFFFFFF, 16'hCAFE, 8'hFF}, 6'd21,
                    {40'h0, 16'hCAFE, 2'b01, 3'b010}};
        vecs[4] = '{3'b100, 2'b11, {32'h01234567, 16'hFFFF, 8'hFF}, 6'd37,
                    {24'h0, 32'h01234567, 2'b11, 3'b100}};
        vecs[5] = '{3'b011, 2'b10, {32'hFFFFFFFF, 16'hBEEF, 8'h5A}, 6'd29,
                    {32'h0, 16'hBEEF, 8'h5A, 2'b10, 3'b011}};

        rst = 1'b1;
        out_ready = 1'b1;
        idle();
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_out_len", {58'd0, out_len}, 64'd0);
        chk("reset_unit_cnt", {32'd0, unit_cnt}, 64'd0);
        #21;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Empty unit is consumed and counted, never emitted.
        e = ref_pack(3'b000, 2'b00, 56'hFF);
        send(3'b000, 2'b00, 56'hFFFF_FFFF_FFFF_FF, e, 1'b1, w);
        idle();
        repeat (4) @(posedge clk);
        #1;
        chk("empty_drop_cnt", {32'd0, drop_cnt}, 64'd1);
        chk("empty_unit_cnt", {32'd0, unit_cnt}, 64'd0);

        // Table vectors, each with an explicit two-cycle latency check.
        for (int i = 0; i < 6; i++) begin
            e.len  = vecs[i].len;
            e.data = vecs[i].data;
            e.due  = -1;
            send(vecs[i].lb, vecs[i].le, vecs[i].d, e, 1'b1, w);
            idle();
            @(negedge clk);
            chk("latency_c1_valid", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
            chk("latency_c2_valid", {63'd0, out_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        drain();
        check_counters("table");

        // Backpressure: two units fill S1+S2, third is refused until release.
        for (int i = 0; i < 4; i++) begin
            bp_lb[i] = 3'($urandom_range(1, 7));
            bp_d[i]  = {$urandom, 24'($urandom)};
            bp[i]    = ref_pack(bp_lb[i], 2'(i), bp_d[i]);
        end
        out_ready = 1'b0;
        send(bp_lb[0], 2'd0, bp_d[0], bp[0], 1'b0, w);
        chk("bp_accept0_waits", 64'(w), 64'd0);
        send(bp_lb[1], 2'd1, bp_d[1], bp[1], 1'b0, w);
        chk("bp_accept1_waits", 64'(w), 64'd0);
        in_valid      = 1'b1;
        in_logb_valid = bp_lb[2];
        in_loge_valid = 2'd2;
        in_logb_data  = bp_d[2];
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(bp_lb[2], 2'd2, bp_d[2], bp[2], 1'b0, w);
        send(bp_lb[3], 2'd3, bp_d[3], bp[3], 1'b0, w);
        idle();
        drain();
        check_counters("bp");

        // Streaming: random units, every one accepted at once, fixed latency.
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            lb = 3'($urandom_range(0, 7));
            le = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                lb = 3'b0;
                le = 2'b0;
            end
            d = {$urandom, 24'($urandom)};
            e = ref_pack(lb, le, d);
            send(lb, le, d, e, 1'b1, w);
            stalls += w;
        end
        idle();
        drain();
        chk("stream_stalls", 64'(stalls), 64'd0);
        check_counters("stream");

        // Reset with both stages full.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = {$urandom, 24'($urandom)};
            e = ref_pack(3'b111, 2'b01, d);
            send(3'b111, 2'b01, d, e, 1'b0, w);
        end
        @(negedge clk);
        chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {3'd0, out_data}, 64'd0);
        chk("rst_out_len", {58'd0, out_len}, 64'd0);
        chk("rst_unit_cnt", {32'd0, unit_cnt}, 64'd0);
        chk("rst_bit_cnt", bit_cnt, 64'd0);
        chk("rst_drop_cnt", {32'd0, drop_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        sb.delete();
        exp_units = 0;
        exp_drops = 0;
        exp_bits  = 0;
        out_ready = 1'b1;
        idle();
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_nothing_emitted", {32'd0, unit_cnt}, 64'd0);
        d = {32'hCAFEF00D, 16'h1234, 8'h56};
        e = ref_pack(3'b110, 2'b10, d);
        send(3'b110, 2'b10, d, e, 1'b1, w);
        idle();
        drain();
        check_counters("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_record_stream_packer.md
# rr_record_stream_packer

Record-side stage directly upstream of the storage backend's record stream consumer. Each cycle it accepts one logging unit in sparse form: a logb/loge valid bitmap plus every logb channel's data in a fixed slot. It compacts the unit into the packed `rr_stream_bus_t` layout, which is LSB→MSB `logb_valid`, `loge_valid`, then the data of the valid channels only. It presents the packed unit with its exact bit length on a valid/ready output that drives `record_bus`.

## Interface

**Parameters**
- `LOGB_CHANNEL_CNT`, default 3: number of logb channels.
- `LOGE_CHANNEL_CNT`, default 2: number of loge channels.
- `CHANNEL_WIDTHS`, default {32,16,8} (index 2..0): `bit [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0]`. Channels are in shuffled order, the same order the backend uses.
- `FULL_WIDTH` (localparam) = sum(`CHANNEL_WIDTHS`) + `LOGB_CHANNEL_CNT` + `LOGE_CHANNEL_CNT`.
- `OFFSET_WIDTH` (localparam) = `$clog2(FULL_WIDTH+1)`.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: sparse unit present.
- `in_ready` out 1: unit accepted when `in_valid && in_ready`.
- `in_logb_valid` in `LOGB_CHANNEL_CNT`: per-channel logb valid.
- `in_loge_valid` in `LOGE_CHANNEL_CNT`: per-channel loge valid.
- `in_logb_data` in sum(`CHANNEL_WIDTHS`): channel i sits at fixed offset sum(`CHANNEL_WIDTHS[0..i-1]`).
- `out_valid` out 1: packed unit present.
- `out_ready` in 1: downstream accepts.
- `out_data` out `FULL_WIDTH`: packed unit; bits at and above `out_len` are 0.
- `out_len` out `OFFSET_WIDTH`: meaningful bit count.
- `unit_cnt` out 32: packed units handed off.
- `bit_cnt` out 64: running sum of `out_len` over handoffs.
- `drop_cnt` out 32: empty units discarded.

## Operation

- **Packing.**
  - `out_data[LOGB-1:0]` = `logb_valid`.
  - `out_data[LOGB+LOGE-1:LOGB]` = `loge_valid`.
  - Valid channels are then appended in ascending index order, each at the running offset.
  - `out_len` = LOGB + LOGE + sum of widths of valid channels.
  - Data of invalid channels is never emitted, even if nonzero.
- **Empty units.** A unit with both bitmaps all-zero is consumed and does not reach the output. It increments `drop_cnt` on acceptance.
- **Stage S1.** Registers the unit and computes the per-channel exclusive prefix offsets of the valid widths, plus `len`.
- **Stage S2.** Performs the shift/OR compaction into a registered `out_data`/`out_len`.
- **Flow control.**
  - Each stage holds a valid flag. A stage loads when it is empty or its content advances in the same cycle.
  - `in_ready` = `!s1_v || !s2_v || out_ready`.
  - An empty unit leaves S1 without occupying S2.
- **Output stability.** `out_data`/`out_len` stay stable while `out_valid && !out_ready`.
- **Counters.** `unit_cnt += 1` and `bit_cnt += out_len` on each output handshake. `drop_cnt += 1` on each accepted empty unit. All counters wrap modulo 2^width.

## Timing

- **Latency.** 2 cycles from input handshake to `out_valid`, for non-empty units.
- **Throughput.** 1 unit/cycle while `out_ready` = 1. No bubbles are inserted between consecutive non-empty units.
- **Stall.** With `out_ready` = 0, at most 2 units are buffered (S1 + S2). `in_ready` falls in the cycle both stages are full. No unit is lost or reordered.
- **Reset.**
  - `rst` asserted clears, immediately and asynchronously: both valids, `out_valid`, `out_data`, `out_len`, and all counters (all 0).
  - `in_ready` is 0 while `rst` = 1 and 1 on the first cycle after deassertion.
- **Reset mid-stream.** In-flight units are discarded and none are emitted after release.
- **Width rule.** `out_len` ≤ `FULL_WIDTH` always fits `OFFSET_WIDTH`. Offset arithmetic is performed at `OFFSET_WIDTH` with no truncation.

## Structure

- **Shared package.** `RR_CHANNEL_WIDTH_BITS`, the sum-width and GET_LEN helper macros/functions, and the prefix-offset function belong in the shared rr package/defs, so they are shared with the backend's length decode.
- **Sub-module.** One sub-module, `rr_packer_offsets`: combinational prefix offsets and total length from the bitmap and `CHANNEL_WIDTHS`. It is instantiated in S1.
- **Parent.** The parent holds the two pipeline registers, the handshake logic and the counters.

## Test plan

All scenarios use the default parameters: `FULL_WIDTH` = 61, `OFFSET_WIDTH` = 6.

- **Sparse unit.** logb=3'b101, loge=2'b00, ch0=8'hA5, ch1=16'hFFFF, ch2=32'hDEADBEEF.
  - `out_len` = 45.
  - `out_data[4:0]` = 5'b00101, `[12:5]` = 8'hA5, `[44:13]` = 32'hDEADBEEF, `[60:45]` = 0.
  - `out_valid` asserts 2 cycles after the input handshake.
- **loge-only unit.** logb=0, loge=2'b10, junk data → `out_len` = 5, `out_data` = 61'h10.
- **Empty unit.** logb=0, loge=0 → no `out_valid`; `drop_cnt` = 1; `unit_cnt` = 0.
- **Backpressure.** `out_ready` = 0, offer 4 non-empty units.
  - Exactly 2 are accepted, then `in_ready` = 0.
  - Raise `out_ready`: all 4 emerge in order with correct lengths.
- **Streaming.** 100 random units with `out_ready` = 1.
  - One output per cycle after the 2-cycle fill.
  - `unit_cnt` = non-empty count, `drop_cnt` = empty count, `bit_cnt` = reference sum of lengths.
- **Reset mid-stream.** Assert `rst` with both stages full.
  - All outputs and counters are 0 within the same cycle.
  - Nothing is emitted after release.
  - The next unit packs correctly.
